// File: rtl/mux4_1_pkg.sv
// Shared width default and select-code constants for the registered 4:1 mux.
package mux4_1_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned SEL_W     = 2;

  localparam logic [SEL_W-1:0] SEL_I1 = 2'b00;
  localparam logic [SEL_W-1:0] SEL_I2 = 2'b01;
  localparam logic [SEL_W-1:0] SEL_I3 = 2'b10;
  localparam logic [SEL_W-1:0] SEL_I4 = 2'b11;

endpackage

// File: rtl/mux4_1_sel.sv
// Purely combinational 4:1 selection; every select code maps to one input.
module mux4_1_sel
  import mux4_1_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  input  logic [SEL_W-1:0] s,
  output logic [WIDTH-1:0] o_sel
);

  always_comb begin
    o_sel = i1;
    unique case (s)
      SEL_I1:  o_sel = i1;
      SEL_I2:  o_sel = i2;
      SEL_I3:  o_sel = i3;
      SEL_I4:  o_sel = i4;
      default: o_sel = i1;
    endcase
  end

endmodule

// File: rtl/mux4_1.sv
// Registered 4:1 mux: one-cycle latency, hold when in_valid is low, async clear.
module mux4_1
  import mux4_1_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  input  logic [SEL_W-1:0] s,
  input  logic             in_valid,
  output logic [WIDTH-1:0] ot,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] r_ot;
  logic             r_out_valid;

  mux4_1_sel #(
    .WIDTH (WIDTH)
  ) u_sel (
    .i1    (i1),
    .i2    (i2),
    .i3    (i3),
    .i4    (i4),
    .s     (s),
    .o_sel (w_sel)
  );

  // Data register only loads on valid so ot holds across idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ot <= '0;
    end else if (in_valid) begin
      r_ot <= w_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
    end
  end

  assign ot        = r_ot;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux4_1.sv
// Randomized self-checking bench for mux4_1 against an array-indexed reference model.
module tb_mux4_1;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] i1, i2, i3, i4;
  logic [1:0]   s;
  logic         in_valid;
  logic [W-1:0] ot;
  logic         out_valid;

  int unsigned  n_checks;
  int unsigned  n_errors;
  logic [W-1:0] exp_ot;
  logic         exp_ov;

  mux4_1 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i1        (i1),
    .i2        (i2),
    .i3        (i3),
    .i4        (i4),
    .s         (s),
    .in_valid  (in_valid),
    .ot        (ot),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic scramble();
    i1 = 4'($urandom()); i2 = 4'($urandom());
    i3 = 4'($urandom()); i4 = 4'($urandom());
    s  = 2'($urandom());
  endtask

  // Apply one cycle of stimulus, update the model, then check at and between edges.
  task automatic drive(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d,
                       input logic [1:0] sel, input logic v);
    logic [W-1:0] pick [4];
    @(negedge clk);
    i1 = a; i2 = b; i3 = c; i4 = d; s = sel; in_valid = v;
    pick[0] = a; pick[1] = b; pick[2] = c; pick[3] = d;
    @(posedge clk);
    if (v) exp_ot = pick[int'(sel)];
    exp_ov = v;
    #1;
    chk({tag, "_ot"}, 32'(ot), 32'(exp_ot));
    chk({tag, "_ov"}, 32'(out_valid), 32'(exp_ov));
    #2;
    scramble();
    #1;
    chk({tag, "_hold_ot"}, 32'(ot), 32'(exp_ot));
    chk({tag, "_hold_ov"}, 32'(out_valid), 32'(exp_ov));
  endtask

  initial begin
    logic [W-1:0] vals [4];
    n_checks = 0;
    n_errors = 0;
    exp_ot   = '0;
    exp_ov   = 1'b0;

    rst_n    = 1'b0;
    in_valid = 1'b1;
    scramble();
    #1;
    chk("reset_ot_pre_edge", 32'(ot), 32'h0);
    chk("reset_ov_pre_edge", 32'(out_valid), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ot_clocked", 32'(ot), 32'h0);
    chk("reset_ov_clocked", 32'(out_valid), 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    drive("sel11", 4'b0000, 4'b0001, 4'b1011, 4'b0010, 2'b11, 1'b1);
    drive("seq_s10", 4'b0000, 4'b0011, 4'b1101, 4'b1000, 2'b10, 1'b1);
    drive("seq_s00", 4'b0000, 4'b0011, 4'b1101, 4'b1000, 2'b00, 1'b1);
    drive("seq_s01", 4'b0000, 4'b0011, 4'b1101, 4'b1000, 2'b01, 1'b1);

    drive("load_1101", 4'b0000, 4'b0011, 4'b1101, 4'b1000, 2'b10, 1'b1);
    drive("idle_a", 4'b1111, 4'b1100, 4'b0010, 4'b0111, 2'b01, 1'b0);
    drive("idle_b", 4'b0000, 4'b0011, 4'b1101, 4'b1000, 2'b00, 1'b0);
    chk("idle_value", 32'(ot), 32'hD);

    drive("all_ones", 4'b1111, 4'b1111, 4'b1111, 4'b1111, 2'b11, 1'b1);
    rst_n = 1'b0;
    #1;
    exp_ot = '0; exp_ov = 1'b0;
    chk("async_rst_ot", 32'(ot), 32'h0);
    chk("async_rst_ov", 32'(out_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive("post_rst", 4'b1111, 4'b1111, 4'b1111, 4'b1111, 2'b11, 1'b1);

    // Reset lands after inputs are set up but before the capturing edge.
    @(negedge clk);
    i1 = 4'h5; i2 = 4'h6; i3 = 4'h7; i4 = 4'h9; s = 2'b10; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    exp_ot = '0; exp_ov = 1'b0;
    chk("midstream_rst_ot", 32'(ot), 32'h0);
    @(posedge clk);
    #1;
    chk("midstream_edge_ot", 32'(ot), 32'h0);
    chk("midstream_edge_ov", 32'(out_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive("resume", 4'h5, 4'h6, 4'h7, 4'h9, 2'b10, 1'b1);

    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) vals[j] = 4'((k * 4 + j * 5 + 3) % 16);
      for (int sel = 0; sel < 4; sel++)
        drive($sformatf("sweep%0d_s%0d", k, sel), vals[0], vals[1], vals[2], vals[3],
              2'(sel), 1'b1);
    end

    for (int n = 0; n < 200; n++) begin
      drive($sformatf("rand%0d", n), 4'($urandom()), 4'($urandom()), 4'($urandom()),
            4'($urandom()), 2'($urandom()), 1'($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mux4_1.md
MUX4_1 -- requirements
Module: mux4_1

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the data width of i1..i4 and ot.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 i1  input  WIDTH  SHALL be data input 0, selected when s=2'b00.
REQ-005 i2  input  WIDTH  SHALL be data input 1, selected when s=2'b01.
REQ-006 i3  input  WIDTH  SHALL be data input 2, selected when s=2'b10.
REQ-007 i4  input  WIDTH  SHALL be data input 3, selected when s=2'b11.
REQ-008 s  input  2  SHALL be the select code.
REQ-009 in_valid  input  1  SHALL mark i1..i4 and s as valid for capture this cycle.
REQ-010 ot  output  WIDTH  SHALL be the registered selected data.
REQ-011 out_valid  output  1  SHALL flag that ot was updated on the last rising edge.

Function
REQ-012 On a rising clk edge with in_valid=1, ot SHALL load the input chosen by s (00->i1, 01->i2, 10->i3, 11->i4), bit-for-bit, with no width change.
REQ-013 Latency SHALL be exactly one clock: inputs sampled at edge N appear on ot after edge N.
REQ-014 out_valid SHALL be registered and equal the in_valid sampled at the same edge.
REQ-015 With in_valid=0, ot SHALL hold its previous value and out_valid SHALL be 0.
REQ-016 Back-to-back in_valid=1 cycles SHALL each produce one update; no bubbles, no backpressure.
REQ-017 Changes on unselected inputs SHALL have no effect on ot.
REQ-018 All four select codes SHALL be decoded; no code is illegal or a hold.
REQ-019 Between clock edges, ot and out_valid SHALL NOT change, except on reset assertion.

Reset
REQ-020 While rst_n=0, ot SHALL be all zeros and out_valid SHALL be 0, taking effect immediately and independent of clk.
REQ-021 Reset asserted mid-stream SHALL discard any capture in progress; after rst_n rises, the first rising edge with in_valid=1 SHALL load normally.
REQ-022 An edge coinciding with reset release SHALL NOT capture; the next edge SHALL be the first that can load.

Structure
REQ-023 Package mux4_1_pkg SHALL hold the WIDTH default and select constants SEL_I1=2'b00, SEL_I2=2'b01, SEL_I3=2'b10, SEL_I4=2'b11.
REQ-024 A combinational sub-module mux4_1_sel, with ports i1..i4, s and a WIDTH-wide result, SHALL perform the selection; mux4_1 SHALL add only the output and valid registers.

Verification
REQ-025 Reset: drive rst_n=0 with random inputs -> ot=4'b0000, out_valid=0 immediately, before any clk edge.
REQ-026 Drive i1=0000, i2=0001, i3=1011, i4=0010, s=11, in_valid=1 -> after one edge, ot=0010 and out_valid=1.
REQ-027 Drive i1=0000, i2=0011, i3=1101, i4=1000, s=10 -> ot=1101; change to s=00 -> ot=0000; change to s=01 -> ot=0011, one update per edge.
REQ-028 Load ot=1101, then drop in_valid=0 and toggle all inputs -> ot holds 1101 and out_valid=0.
REQ-029 All inputs 1111 with s=11, then rst_n pulsed low between edges -> ot drops to 0000 asynchronously and resumes loading on the first edge after release.
REQ-030 Exhaustive sweep of all 4 select codes against distinct input values -> every ot matches the mapping in REQ-012.
